unpacked_array_deser: RTL and testbench
=======================================

// Module: unpacked_array_deser
// PURPOSE
//   Serial-to-parallel receiver: collects a framed stream of single bits into an
//   unpacked array sized by parameter (logic p [M]), then presents the completed
//   M-bit word on a valid/ready output. Receive-side counterpart of the parallel-in
//   / serial-out stage; also exercises sized unpacked arrays under TMR expansion.
// PARAMETERS
//   M        2   word width in bits = depth of unpacked array p [M]; legal M >= 2
// PORTS
//   clock     in   1   system clock, all state on rising edge
//   reset_n   in   1   asynchronous active-low reset
//   d         in   1   serial data bit, sampled when d_valid=1
//   d_valid   in   1   d carries a valid bit this cycle
//   sof       in   1   start-of-frame; qualifies the first bit of a word (with d_valid)
//   q         out  M   assembled word; q[i] = i-th bit received (LSB first)
//   q_valid   out  1   q holds an unconsumed word
//   q_ready   in   1   consumer accepts q when q_valid & q_ready
//   ovf_err   out  1   sticky: a completed word was dropped (output still full)
//   sync_err  out  1   sticky: sof seen before current word completed
//   err_clr   in   1   synchronous clear of both sticky error flags
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, cnt=0, p[0..M-1]=0, q=0, q_valid=0,
//     ovf_err=0, sync_err=0. Reset mid-word discards the partial word.
//   Storage: logic p [M] (size form, index 0..M-1); cnt width $clog2(M), counts
//     bits already stored in the current word.
//   FSM states: IDLE, COLLECT.
//   IDLE: d_valid & sof -> p[0]<=d, cnt<=1, go COLLECT. d_valid & !sof -> bit
//     ignored (no error). d_valid=0 -> hold.
//   COLLECT, d_valid=0: hold all state (gaps of any length allowed).
//   COLLECT, d_valid & sof: partial word discarded, p[0]<=d, cnt<=1, stay COLLECT,
//     sync_err<=1.
//   COLLECT, d_valid & !sof: p[cnt]<=d, cnt<=cnt+1. If cnt==M-1 the word completes:
//     go IDLE, cnt<=0, and:
//     - output free (q_valid=0, or q_valid & q_ready this cycle): q<={d,p[M-2..0]}
//       packed (q[M-1]=d), q_valid<=1 next cycle.
//     - output full and not being consumed: word dropped, q/q_valid unchanged,
//       ovf_err<=1.
//   Latency: q_valid rises the cycle after the edge sampling the M-th bit.
//   Output handshake: q, q_valid stable while q_valid & !q_ready. q_valid & q_ready
//     with no completing word -> q_valid<=0 next cycle, q retains last value.
//     Simultaneous accept and completion -> new word loaded, q_valid stays 1.
//   Back-to-back: sof may arrive the cycle after completion (in IDLE); one bit per
//     cycle sustained -> one word per M cycles, no gap required.
//   Errors: err_clr=1 clears both flags next cycle; if a new error event occurs in
//     the same cycle as err_clr, the flag is set (set wins). Flags never affect data.
//   Arithmetic: cnt never exceeds M-1; no wrap beyond M-1 as completion resets it.
// TESTING  (M=4 unless stated)
//   1 Reset: assert reset_n=0 mid-word -> q=0, q_valid=0, errs=0 immediately; next
//     word 1,0,1,1 (sof on first) -> q=4'b1101, q_valid=1 one cycle after 4th bit.
//   2 Gaps/hold: bits 0,1,1,0 with d_valid low 3 cycles between each, q_ready=1 ->
//     single q=4'b0110 pulse, q_valid high exactly 1 cycle.
//   3 Backpressure: q_ready=0, send 4'b0011 then 4'b1000 -> q stays 4'b0011,
//     ovf_err=1 after 2nd word; raise q_ready -> q_valid drops, ovf_err stays 1;
//     err_clr pulse -> ovf_err=0.
//   4 Simultaneous: q_valid=1 (4'b1111), q_ready=1 on cycle 4th bit of 4'b0101
//     lands -> q=4'b0101 next cycle, q_valid continuously 1, ovf_err=0.
//   5 Resync: sof,1,0 then sof,0,0,1,1 -> sync_err=1, q=4'b1100 only, no 3-bit word.
//   6 Streaming, M=2 and M=8: continuous d_valid, sof every M cycles, q_ready=1 ->
//     every word delivered, one q_valid per M cycles, bit order LSB first, no errors.

Source files
------------

// File: rtl/unpacked_array_deser.sv
// Serial-to-parallel receiver.
// Framed single-bit input is collected LSB first into an unpacked array
// p [M]. Each completed M-bit word is presented on a valid/ready output.
// Sticky flags report dropped words (overflow) and early start-of-frame
// (resync). err_clr clears both flags; a new error event in the same cycle
// wins over the clear.
module unpacked_array_deser #(
    parameter int M = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         d,
    input  logic         d_valid,
    input  logic         sof,
    output logic [M-1:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         ovf_err,
    output logic         sync_err,
    input  logic         err_clr
);

    // Bit counter: number of bits already stored in the current word.
    localparam int                 CNT_W = $clog2(M);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0]   ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               p_q [M];
    logic               p_d [M];
    logic [M-1:0]       word_q, word_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               sync_q, sync_d;

    // Completed word is the stored bits plus the bit arriving this cycle.
    logic [M-1:0]       full_word;
    logic               out_free;

    // Packs the stored bits and the in-flight last bit into the output word.
    always_comb begin
        for (int i = 0; i < M - 1; i++) begin
            full_word[i] = p_q[i];
        end
        full_word[M-1] = d;
    end

    // The output slot can take a new word if empty or being drained now.
    assign out_free = !valid_q || q_ready;

    // Next-state, datapath and flag update for the receive FSM.
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        word_d  = word_q;
        valid_d = valid_q;
        // Clear is applied first so that any error event below overrides it.
        ovf_d   = err_clr ? 1'b0 : ovf_q;
        sync_d  = err_clr ? 1'b0 : sync_q;

        // Consumer drains the current word; a completion below may refill it.
        if (valid_q && q_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // Bits outside a frame are silently ignored.
                if (d_valid && sof) begin
                    p_d[0]  = d;
                    cnt_d   = ONE;
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (d_valid) begin
                    if (sof) begin
                        // Early start-of-frame: drop the partial word and restart.
                        p_d[0] = d;
                        cnt_d  = ONE;
                        sync_d = 1'b1;
                    end else begin
                        p_d[cnt_q] = d;
                        if (cnt_q == LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            if (out_free) begin
                                word_d  = full_word;
                                valid_d = 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, storage array and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the bit array is small and reset is required to clear a
            // partial word, so it is reset like any other flop; large RAMs
            // would normally be left unreset.
            for (int i = 0; i < M; i++) begin
                p_q[i] <= 1'b0;
            end
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            sync_q  <= sync_d;
        end
    end

    assign q        = word_q;
    assign q_valid  = valid_q;
    assign ovf_err  = ovf_q;
    assign sync_err = sync_q;

endmodule

// File: tb/tb_unpacked_array_deser.sv
// Self-checking bench for unpacked_array_deser: table-driven vectors on an
// M=4 instance, plus hand-written reset, gap and streaming (M=2, M=8) runs.
module tb_unpacked_array_deser;

    logic clock;
    logic reset_n;

    // M=4 instance signals
    logic       d4, dv4, sof4, rdy4, clr4;
    logic [3:0] q4;
    logic       qv4, ovf4, sync4;

    // M=2 instance signals
    logic       d2, dv2, sof2, rdy2, clr2;
    logic [1:0] q2;
    logic       qv2, ovf2, sync2;

    // M=8 instance signals
    logic       d8, dv8, sof8, rdy8, clr8;
    logic [7:0] q8;
    logic       qv8, ovf8, sync8;

    int checks = 0;
    int errors = 0;

    unpacked_array_deser #(.M(4)) u4 (
        .clock(clock), .reset_n(reset_n), .d(d4), .d_valid(dv4), .sof(sof4),
        .q(q4), .q_valid(qv4), .q_ready(rdy4), .ovf_err(ovf4),
        .sync_err(sync4), .err_clr(clr4)
    );

    unpacked_array_deser #(.M(2)) u2 (
        .clock(clock), .reset_n(reset_n), .d(d2), .d_valid(dv2), .sof(sof2),
        .q(q2), .q_valid(qv2), .q_ready(rdy2), .ovf_err(ovf2),
        .sync_err(sync2), .err_clr(clr2)
    );

    unpacked_array_deser #(.M(8)) u8 (
        .clock(clock), .reset_n(reset_n), .d(d8), .d_valid(dv8), .sof(sof8),
        .q(q8), .q_valid(qv8), .q_ready(rdy8), .ovf_err(ovf8),
        .sync_err(sync8), .err_clr(clr8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       dv;
        logic       sof;
        logic       d;
        logic       rdy;
        logic       clr;
        logic [3:0] q;
        logic       v;
        logic       ovf;
        logic       sync;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic dv, input logic sof, input logic d, input logic rdy,
                       input logic clr, input logic [3:0] q, input logic v,
                       input logic ovf, input logic sync);
        vec_t t;
        t.dv = dv; t.sof = sof; t.d = d; t.rdy = rdy; t.clr = clr;
        t.q = q; t.v = v; t.ovf = ovf; t.sync = sync;
        vecs.push_back(t);
    endtask

    // One clock: inputs already set; outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send4(input logic d, input logic sof);
        d4 = d; sof4 = sof; dv4 = 1'b1;
        step();
        dv4 = 1'b0; sof4 = 1'b0;
    endtask

    logic [1:0] w2 [5];
    logic [7:0] w8 [4];
    int         hi_cnt;
    logic [3:0] gap_bits;

    initial begin
        reset_n = 1'b0;
        {d4, dv4, sof4, rdy4, clr4} = '0;
        {d2, dv2, sof2, rdy2, clr2} = '0;
        {d8, dv8, sof8, rdy8, clr8} = '0;
        step();
        step();
        check("rst.q", 32'(q4), 32'h0);
        check("rst.q_valid", 32'(qv4), 32'h0);
        check("rst.errs", 32'({ovf4, sync4}), 32'h0);
        reset_n = 1'b1;
        step();

        // ---- Reset mid-word discards everything, asynchronously ----
        send4(1, 1); send4(1, 0); send4(1, 0); send4(1, 0);
        check("pre.q", 32'(q4), 32'hF);
        check("pre.q_valid", 32'(qv4), 32'h1);
        send4(1, 1); send4(0, 1);
        check("pre.sync_err", 32'(sync4), 32'h1);
        send4(1, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst.q", 32'(q4), 32'h0);
        check("async_rst.q_valid", 32'(qv4), 32'h0);
        check("async_rst.errs", 32'({ovf4, sync4}), 32'h0);
        step();
        reset_n = 1'b1;

        // ---- Table-driven vectors (M=4) ----
        //  dv sof d rdy clr  q        v ovf sync
        add(1, 1, 1, 0, 0, 4'b0000, 0, 0, 0);  // word 1,0,1,1 after reset
        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        add(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
        add(1, 0, 1, 0, 0, 4'b1101, 1, 0, 0);
        add(0, 0, 0, 1, 0, 4'b1101, 0, 0, 0);  // accept, q retained
        add(1, 1, 1, 0, 0, 4'b1101, 0, 0, 0);  // backpressure: 4'b0011
        add(1, 0, 1, 0, 0, 4'b1101, 0, 0, 0);
        add(1, 0, 0, 0, 0, 4'b1101, 0, 0, 0);
        add(1, 0, 0, 0, 0, 4'b0011, 1, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0011, 1, 0, 0);  // then 4'b1000, dropped
        add(1, 0, 0, 0, 0, 4'b0011, 1, 0, 0);
        add(1, 0, 0, 0, 0, 4'b0011, 1, 0, 0);
        add(1, 0, 1, 0, 0, 4'b0011, 1, 1, 0);
        add(0, 0, 0, 1, 0, 4'b0011, 0, 1, 0);  // drain, ovf sticky
        add(0, 0, 0, 0, 1, 4'b0011, 0, 0, 0);  // err_clr
        add(1, 1, 1, 0, 0, 4'b0011, 0, 0, 0);  // load 4'b1111, hold
        add(1, 0, 1, 0, 0, 4'b0011, 0, 0, 0);
        add(1, 0, 1, 0, 0, 4'b0011, 0, 0, 0);
        add(1, 0, 1, 0, 0, 4'b1111, 1, 0, 0);
        add(1, 1, 1, 0, 0, 4'b1111, 1, 0, 0);  // 4'b0101, accept on last bit
        add(1, 0, 0, 0, 0, 4'b1111, 1, 0, 0);
        add(1, 0, 1, 0, 0, 4'b1111, 1, 0, 0);
        add(1, 0, 0, 1, 0, 4'b0101, 1, 0, 0);
        add(0, 0, 0, 1, 0, 4'b0101, 0, 0, 0);
        add(1, 1, 1, 0, 0, 4'b0101, 0, 0, 0);  // resync: sof,1,0 then sof,0,0,1,1
        add(1, 0, 0, 0, 0, 4'b0101, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0101, 0, 0, 1);
        add(1, 0, 0, 0, 0, 4'b0101, 0, 0, 1);
        add(1, 0, 1, 0, 0, 4'b0101, 0, 0, 1);
        add(1, 0, 1, 0, 0, 4'b1100, 1, 0, 1);
        add(0, 0, 0, 1, 0, 4'b1100, 0, 0, 1);
        add(0, 0, 0, 0, 1, 4'b1100, 0, 0, 0);
        add(1, 1, 1, 0, 0, 4'b1100, 0, 0, 0);  // sync event with err_clr: set wins
        add(1, 1, 0, 0, 1, 4'b1100, 0, 0, 1);
        add(1, 0, 1, 0, 1, 4'b1100, 0, 0, 0);
        add(1, 0, 0, 0, 0, 4'b1100, 0, 0, 0);
        add(1, 0, 1, 0, 0, 4'b1010, 1, 0, 0);
        add(1, 0, 1, 1, 0, 4'b1010, 0, 0, 0);  // unframed bits in IDLE ignored
        add(1, 0, 0, 0, 0, 4'b1010, 0, 0, 0);

        foreach (vecs[i]) begin
            dv4 = vecs[i].dv; sof4 = vecs[i].sof; d4 = vecs[i].d;
            rdy4 = vecs[i].rdy; clr4 = vecs[i].clr;
            step();
            check($sformatf("vec%0d.q", i), 32'(q4), 32'(vecs[i].q));
            check($sformatf("vec%0d.q_valid", i), 32'(qv4), 32'(vecs[i].v));
            check($sformatf("vec%0d.ovf_err", i), 32'(ovf4), 32'(vecs[i].ovf));
            check($sformatf("vec%0d.sync_err", i), 32'(sync4), 32'(vecs[i].sync));
        end
        {dv4, sof4, d4, clr4} = '0;

        // ---- Gaps: bits 0,1,1,0 with 3 idle cycles between, q_ready=1 ----
        rdy4 = 1'b1;
        gap_bits = 4'b0110;
        hi_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            d4 = gap_bits[b]; sof4 = (b == 0); dv4 = 1'b1;
            step();
            dv4 = 1'b0; sof4 = 1'b0;
            if (qv4) hi_cnt++;
            check($sformatf("gap.bit%0d.q_valid", b), 32'(qv4), 32'(b == 3));
            if (b == 3) check("gap.q", 32'(q4), 32'h6);
            for (int g = 0; g < 3; g++) begin
                step();
                if (qv4) hi_cnt++;
            end
        end
        check("gap.valid_cycles", 32'(hi_cnt), 32'h1);
        check("gap.errs", 32'({ovf4, sync4}), 32'h0);

        // ---- Streaming M=2: continuous bits, q_ready=1 ----
        w2[0] = 2'b01; w2[1] = 2'b10; w2[2] = 2'b11; w2[3] = 2'b00; w2[4] = 2'b01;
        rdy2 = 1'b1;
        for (int w = 0; w < 5; w++) begin
            for (int b = 0; b < 2; b++) begin
                d2 = w2[w][b]; sof2 = (b == 0); dv2 = 1'b1;
                step();
                check($sformatf("m2.w%0d.b%0d.q_valid", w, b), 32'(qv2), 32'(b == 1));
                if (b == 1) check($sformatf("m2.w%0d.q", w), 32'(q2), 32'(w2[w]));
            end
        end
        dv2 = 1'b0; sof2 = 1'b0;
        step();
        check("m2.drain", 32'(qv2), 32'h0);
        check("m2.errs", 32'({ovf2, sync2}), 32'h0);

        // ---- Streaming M=8: continuous bits, q_ready=1 ----
        w8[0] = 8'hA5; w8[1] = 8'h3C; w8[2] = 8'h01; w8[3] = 8'h80;
        rdy8 = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 8; b++) begin
                d8 = w8[w][b]; sof8 = (b == 0); dv8 = 1'b1;
                step();
                check($sformatf("m8.w%0d.b%0d.q_valid", w, b), 32'(qv8), 32'(b == 7));
                if (b == 7) check($sformatf("m8.w%0d.q", w), 32'(q8), 32'(w8[w]));
            end
        end
        dv8 = 1'b0; sof8 = 1'b0;
        step();
        check("m8.drain", 32'(qv8), 32'h0);
        check("m8.errs", 32'({ovf8, sync8}), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
